// File: rtl/pi_pkg.sv
// Shared definitions for the pi-tree deflection arbiter: port indices and
// packet field offsets derived from the tree size and payload width.
package pi_pkg;

    localparam logic [1:0] P_L  = 2'd0;
    localparam logic [1:0] P_R  = 2'd1;
    localparam logic [1:0] P_UL = 2'd2;
    localparam logic [1:0] P_UR = 2'd3;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] port_t;

    function automatic int addr_w(input int num_leaves);
        return $clog2(num_leaves);
    endfunction

    // Packet layout, MSB first: valid, dest[A-1:0], payload[payload_sz-1:0].
    function automatic int valid_bit(input int num_leaves, input int payload_sz);
        return addr_w(num_leaves) + payload_sz;
    endfunction

    function automatic int dest_lo(input int payload_sz);
        return payload_sz;
    endfunction

    function automatic int dest_hi(input int num_leaves, input int payload_sz);
        return payload_sz + addr_w(num_leaves) - 1;
    endfunction

    function automatic int payload_hi(input int payload_sz);
        return payload_sz - 1;
    endfunction

endpackage

// File: rtl/pi_route_decode.sv
// Per-input route decode: does the destination fall inside this switch's
// subtree, and if so which child; otherwise the packet heads upward.
module pi_route_decode
    import pi_pkg::*;
#(
    parameter int num_leaves = 2,
    parameter int addr       = 0,
    parameter int level      = 1,
    parameter int A          = $clog2(num_leaves)
) (
    input  logic [A-1:0] dest,
    output logic         up,
    output logic [1:0]   pref
);

    logic [A-1:0] upper;
    logic         match;

    assign upper = dest >> level;
    assign match = (upper == A'(addr));

    // Up-bound packets name ul as their first choice; ur is the fallback.
    assign up   = !match;
    assign pref = match ? (dest[level-1] ? P_R : P_L) : P_UL;

endmodule

// File: rtl/pi_deflect_arbiter.sv
// Bufferless pi-tree switch: rotating-priority grant of preferred outputs,
// deflection of losers to free outputs, registered outputs, deflect counter.
module pi_deflect_arbiter
    import pi_pkg::*;
#(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int addr       = 0,
    parameter int level      = 1,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
    parameter int cnt_w      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [p_sz-1:0]  l_bus_i,
    input  logic [p_sz-1:0]  r_bus_i,
    input  logic [p_sz-1:0]  ul_bus_i,
    input  logic [p_sz-1:0]  ur_bus_i,
    output logic [p_sz-1:0]  l_bus_o,
    output logic [p_sz-1:0]  r_bus_o,
    output logic [p_sz-1:0]  ul_bus_o,
    output logic [p_sz-1:0]  ur_bus_o,
    input  logic             cnt_clr,
    output logic [cnt_w-1:0] deflect_cnt,
    output logic             conflict
);

    localparam int A  = addr_w(num_leaves);
    localparam int VB = valid_bit(num_leaves, payload_sz);
    localparam int DL = dest_lo(payload_sz);
    localparam int DH = dest_hi(num_leaves, payload_sz);

    logic [p_sz-1:0]  in_bus   [NUM_PORTS];
    logic [p_sz-1:0]  out_next [NUM_PORTS];
    logic [p_sz-1:0]  out_reg  [NUM_PORTS];
    logic [3:0]       in_valid;
    logic [3:0]       go_up;
    logic [1:0]       pref     [NUM_PORTS];

    logic [3:0]       claim_next;
    logic [1:0]       src_next [NUM_PORTS];
    logic [3:0]       placed;
    logic [2:0]       ndef_next;
    logic [1:0]       idx;

    logic [1:0]       ptr_reg;
    logic [cnt_w-1:0] cnt_reg;
    logic [cnt_w-1:0] cnt_next;
    logic [cnt_w:0]   cnt_sum;
    logic             conflict_reg;

    assign in_bus[P_L]  = l_bus_i;
    assign in_bus[P_R]  = r_bus_i;
    assign in_bus[P_UL] = ul_bus_i;
    assign in_bus[P_UR] = ur_bus_i;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
            assign in_valid[gi] = in_bus[gi][VB];

            pi_route_decode #(
                .num_leaves (num_leaves),
                .addr       (addr),
                .level      (level),
                .A          (A)
            ) u_dec (
                .dest (in_bus[gi][DH:DL]),
                .up   (go_up[gi]),
                .pref (pref[gi])
            );
        end
    endgenerate

    always_comb begin
        claim_next = '0;
        placed     = '0;
        ndef_next  = '0;
        idx        = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            src_next[o] = '0;
        end

        // Grant pass: each valid input in priority order tries its preferred port.
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_reg + 2'(k);
            if (in_valid[idx]) begin
                if (!claim_next[pref[idx]]) begin
                    claim_next[pref[idx]] = 1'b1;
                    src_next[pref[idx]]   = idx;
                    placed[idx]           = 1'b1;
                end else if (go_up[idx] && !claim_next[P_UR]) begin
                    claim_next[P_UR] = 1'b1;
                    src_next[P_UR]   = idx;
                    placed[idx]      = 1'b1;
                end
            end
        end

        // Deflect pass: losers take the lowest-numbered free port; never fails.
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_reg + 2'(k);
            if (in_valid[idx] && !placed[idx]) begin
                for (int o = 0; o < NUM_PORTS; o++) begin
                    if (!placed[idx] && !claim_next[o]) begin
                        claim_next[o] = 1'b1;
                        src_next[o]   = idx;
                        placed[idx]   = 1'b1;
                        ndef_next     = ndef_next + 3'd1;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            assign out_next[gi] = claim_next[gi] ? in_bus[src_next[gi]] : '0;
        end
    endgenerate

    // One spare bit catches the carry so the count saturates instead of wrapping.
    assign cnt_sum = {1'b0, cnt_reg} + (cnt_w + 1)'(ndef_next);

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (cnt_sum[cnt_w]) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[cnt_w-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_reg[o] <= '0;
            end
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            conflict_reg <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_reg[o] <= out_next[o];
            end
            cnt_reg      <= cnt_next;
            conflict_reg <= (ndef_next != 3'd0);
            if (ndef_next != 3'd0) begin
                ptr_reg <= ptr_reg + 2'd1;
            end
        end
    end

    assign l_bus_o     = out_reg[P_L];
    assign r_bus_o     = out_reg[P_R];
    assign ul_bus_o    = out_reg[P_UL];
    assign ur_bus_o    = out_reg[P_UR];
    assign deflect_cnt = cnt_reg;
    assign conflict    = conflict_reg;

endmodule

// File: doc/pi_deflect_arbiter.md
Name: pi_deflect_arbiter

Overview:
- Routing and arbitration controller for one bufferless pi-tree switch position inside a cluster.
- Takes the four packet inputs (left, right, up-left, up-right) and decodes each destination against this switch's subtree.
- Resolves output contention with a rotating-priority pointer and deflects losers to free outputs, so every valid input leaves every cycle.
- Drives registered outputs and keeps a saturating deflection counter for network tuning.

Parameters:
- num_leaves, 2, leaf count of the whole tree; A = $clog2(num_leaves) address bits.
- payload_sz, 1, payload bits per packet.
- addr, 0, subtree index of this switch (integer, A-level significant bits).
- level, 1, tree level; 1 = adjacent to leaves; must satisfy 1 <= level <= A.
- p_sz, 1+A+payload_sz, packet width; bit p_sz-1 = valid, next A bits = dest, low payload_sz bits = payload.
- cnt_w, 16, deflection counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- l_bus_i  in  p_sz  packet from left child
- r_bus_i  in  p_sz  packet from right child
- ul_bus_i  in  p_sz  packet from up-left parent
- ur_bus_i  in  p_sz  packet from up-right parent
- l_bus_o  out  p_sz  packet to left child
- r_bus_o  out  p_sz  packet to right child
- ul_bus_o  out  p_sz  packet to up-left parent
- ur_bus_o  out  p_sz  packet to up-right parent
- cnt_clr  in  1  synchronous clear of deflect_cnt
- deflect_cnt  out  cnt_w  saturating count of deflected packets
- conflict  out  1  registered; high the cycle after any deflection

Behaviour:
- Reset is asynchronous, active-high, on clk. While reset is high: all four bus outputs = 0 (valid low), deflect_cnt = 0, conflict = 0, priority pointer ptr (2 bits) = 0.
- Decode, per valid input: match = (dest >> level) == addr.
  - If match, the preferred output is down: dest[level-1] = 0 selects l_bus_o; 1 selects r_bus_o.
  - If not match, the preferred output is up: ul_bus_o first choice, ur_bus_o equally acceptable.
- Input indices: 0 = l, 1 = r, 2 = ul, 3 = ur.
- Pass 1, grant: visit inputs in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). Each valid input takes its preferred output if that output is unclaimed. Up-bound inputs take ul, else ur.
- Pass 2, deflect: visit the remaining valid inputs in the same priority order. Each takes the first unclaimed output in the order l, r, ul, ur. This pass always succeeds because there are 4 inputs and 4 outputs.
- Invalid inputs claim nothing. Unclaimed outputs drive all zeros.
- Latency is exactly 1 cycle: outputs are registered from the current inputs, and the packet is copied bit-exact.
- ndef = number of inputs placed in pass 2 (0..3).
- When ndef > 0: ptr <= ptr + 1 (mod 4) and conflict <= 1. Otherwise ptr holds and conflict <= 0.
- deflect_cnt <= min(deflect_cnt + ndef, 2^cnt_w - 1), saturating with no wrap.
- cnt_clr has priority over increment: deflect_cnt <= 0 that cycle, while ptr and conflict still update normally.
- Reset asserted mid-stream: packets in the output registers are dropped (outputs forced to 0 immediately). The first post-reset grant uses ptr = 0.

Decomposition:
- Shared package pi_pkg:
  - packet field offset functions (valid bit index, dest slice, payload slice) derived from num_leaves/payload_sz;
  - port index constants P_L=0, P_R=1, P_UL=2, P_UR=3.
- One natural sub-module, pi_route_decode: combinational per-input match and preferred-direction decode (instantiated 4 times).
- Allocation, pointer and counter stay in this module.

Test Plan:
Configuration: num_leaves=8, payload_sz=4, p_sz=8, level=1, addr=0. Encodings: 0x85 = dest 0, payload 5; 0x93 = dest 1; 0xCA = dest 4.
- Single down, single up: l_bus_i=0x85 -> next cycle l_bus_o=0x85 and other outputs 0, conflict=0. Then l_bus_i=0xCA -> ul_bus_o=0xCA.
- Two-way conflict with rotation: ptr=0, l_i=r_i=0x85 -> l_bus_o=0x85 (from l), r_bus_o=0x85 (from r, deflected), conflict=1, deflect_cnt=1, ptr=1. Repeat with r_i=0x86 -> l_bus_o=0x86, r_bus_o=0x85, cnt=2.
- Full load, no conflict: l=0xCA, r=0xCB, ul=0x85, ur=0x93 -> ul_o=0xCA, ur_o=0xCB, l_o=0x85, r_o=0x93, conflict=0, cnt unchanged.
- Four-way conflict: all inputs 0x85 from reset -> l_o takes l; r, ul and ur are deflected to r_o, ul_o, ur_o; cnt += 3.
- Saturation and clear (cnt_w=2): apply the four-way conflict twice -> cnt=3 and holds at 3. Assert cnt_clr during a conflict cycle -> cnt=0, conflict=1.
- Async reset mid-traffic: assert reset between clock edges -> outputs 0 immediately. After release, two-way conflict gives the l-input grant (ptr=0).
